// File: rtl/memory_access_unit.sv
// Memory stage: issues data-memory loads/stores over a req/ack handshake,
// formats byte/word data and holds the M/W pipeline register.
module memory_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     alu_result_m_i,
  input  logic [DATA_WIDTH-1:0]     write_data_m_i,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_m_i,
  input  logic [DATA_WIDTH-1:0]     imm_ext_m_i,
  input  logic [REGISTER_WIDTH-1:0] rd_m_i,
  input  logic [1:0]                result_src_m_i,
  input  logic                      reg_write_m_i,
  input  logic                      mem_write_m_i,
  input  logic                      byte_op_m_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [DATA_WIDTH-1:0]     dmem_addr_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  output logic [3:0]                dmem_be_o,
  input  logic                      dmem_ack_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic                      stall_m_o,
  output logic                      misaligned_o,
  output logic [DATA_WIDTH-1:0]     alu_result_w_o,
  output logic [DATA_WIDTH-1:0]     read_data_w_o,
  output logic [DATA_WIDTH-1:0]     pc_plus4_w_o,
  output logic [DATA_WIDTH-1:0]     imm_ext_w_o,
  output logic [REGISTER_WIDTH-1:0] rd_w_o,
  output logic [1:0]                result_src_w_o,
  output logic                      reg_write_w_o
);

  // Memory handshake: dmem_req_o rises with the request fields and they stay
  // stable until the cycle dmem_ack_i is high; that cycle completes the
  // transfer (rdata valid) and req drops on the next edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                  mem_op;
  logic                  misaligned;
  logic                  issue;
  logic                  capture;
  logic                  load_buf;
  logic                  use_buf;
  logic                  flag_misaligned;
  logic [1:0]            lane_q;
  logic                  byte_q;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic [DATA_WIDTH-1:0] load_buf_q;

  assign mem_op     = mem_write_m_i | (result_src_m_i == 2'b01);
  assign misaligned = mem_op & ~byte_op_m_i & (alu_result_m_i[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_op && !misaligned) state_next = BUSY;
      BUSY:    if (dmem_ack_i) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    stall_m_o       = 1'b0;
    issue           = 1'b0;
    capture         = 1'b0;
    load_buf        = 1'b0;
    use_buf         = 1'b0;
    flag_misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall_m_o = 1'b1;
          issue     = 1'b1;
        end else begin
          capture         = 1'b1;
          flag_misaligned = misaligned;
        end
      end
      BUSY: begin
        stall_m_o = 1'b1;
        load_buf  = dmem_ack_i;
      end
      DONE: begin
        capture = 1'b1;
        use_buf = 1'b1;
      end
      default: begin
        stall_m_o = 1'b0;
      end
    endcase
  end

  // Request registers; lane and size are kept so load formatting does not
  // depend on the M inputs while the access is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= 4'b0000;
      lane_q       <= 2'b00;
      byte_q       <= 1'b0;
    end else if (issue) begin
      dmem_req_o  <= 1'b1;
      dmem_we_o   <= mem_write_m_i;
      dmem_addr_o <= {alu_result_m_i[DATA_WIDTH-1:2], 2'b00};
      lane_q      <= alu_result_m_i[1:0];
      byte_q      <= byte_op_m_i;
      if (byte_op_m_i) begin
        dmem_be_o    <= 4'b0001 << alu_result_m_i[1:0];
        dmem_wdata_o <= {4{write_data_m_i[7:0]}};
      end else begin
        dmem_be_o    <= 4'b1111;
        dmem_wdata_o <= write_data_m_i;
      end
    end else if (load_buf) begin
      dmem_req_o <= 1'b0;
    end
  end

  always_comb begin
    load_fmt = dmem_rdata_i;
    if (byte_q) begin
      case (lane_q)
        2'd0:    load_fmt = {{(DATA_WIDTH-8){1'b0}}, dmem_rdata_i[7:0]};
        2'd1:    load_fmt = {{(DATA_WIDTH-8){1'b0}}, dmem_rdata_i[15:8]};
        2'd2:    load_fmt = {{(DATA_WIDTH-8){1'b0}}, dmem_rdata_i[23:16]};
        default: load_fmt = {{(DATA_WIDTH-8){1'b0}}, dmem_rdata_i[31:24]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_buf_q <= '0;
    end else if (load_buf) begin
      load_buf_q <= dmem_we_o ? '0 : load_fmt;
    end
  end

  // M/W register: captures the instruction when it leaves M, otherwise a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_w_o <= '0;
      read_data_w_o  <= '0;
      pc_plus4_w_o   <= '0;
      imm_ext_w_o    <= '0;
      rd_w_o         <= '0;
      result_src_w_o <= 2'b00;
      reg_write_w_o  <= 1'b0;
      misaligned_o   <= 1'b0;
    end else begin
      misaligned_o <= flag_misaligned;
      if (capture) begin
        alu_result_w_o <= alu_result_m_i;
        read_data_w_o  <= use_buf ? load_buf_q : '0;
        pc_plus4_w_o   <= pc_plus4_m_i;
        imm_ext_w_o    <= imm_ext_m_i;
        rd_w_o         <= rd_m_i;
        result_src_w_o <= result_src_m_i;
        reg_write_w_o  <= reg_write_m_i & ~flag_misaligned;
      end else begin
        alu_result_w_o <= '0;
        read_data_w_o  <= '0;
        pc_plus4_w_o   <= '0;
        imm_ext_w_o    <= '0;
        rd_w_o         <= '0;
        result_src_w_o <= 2'b00;
        reg_write_w_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed vector table, reset corner case and
// randomized instructions checked against a transaction-level model.
module tb_memory_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result_m_i, write_data_m_i, pc_plus4_m_i, imm_ext_m_i;
  logic [4:0]  rd_m_i;
  logic [1:0]  result_src_m_i;
  logic        reg_write_m_i, mem_write_m_i, byte_op_m_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_m_o, misaligned_o;
  logic [31:0] alu_result_w_o, read_data_w_o, pc_plus4_w_o, imm_ext_w_o;
  logic [4:0]  rd_w_o;
  logic [1:0]  result_src_w_o;
  logic        reg_write_w_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu, wd, pc, imm;
    logic [4:0]  rd;
    logic [1:0]  rsrc;
    logic        rw, mw, bop;
  } instr_t;

  typedef struct {
    instr_t      t;
    int          ack_on;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_read;
    logic        exp_mis;
  } vec_t;

  memory_access_unit #(.DATA_WIDTH(32), .REGISTER_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_m_i(alu_result_m_i), .write_data_m_i(write_data_m_i),
    .pc_plus4_m_i(pc_plus4_m_i), .imm_ext_m_i(imm_ext_m_i), .rd_m_i(rd_m_i),
    .result_src_m_i(result_src_m_i), .reg_write_m_i(reg_write_m_i),
    .mem_write_m_i(mem_write_m_i), .byte_op_m_i(byte_op_m_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_m_o(stall_m_o), .misaligned_o(misaligned_o),
    .alu_result_w_o(alu_result_w_o), .read_data_w_o(read_data_w_o),
    .pc_plus4_w_o(pc_plus4_w_o), .imm_ext_w_o(imm_ext_w_o), .rd_w_o(rd_w_o),
    .result_src_w_o(result_src_w_o), .reg_write_w_o(reg_write_w_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic is_mem(input instr_t t);
    return t.mw || (t.rsrc == 2'b01);
  endfunction

  // Reference model: what one instruction should produce, from the access rules
  task automatic model(input instr_t t, input logic [31:0] rdata,
                       output logic [3:0] be, output logic [31:0] wdata,
                       output logic [31:0] rd_data, output logic mis);
    int lane;
    lane  = int'(t.alu % 4);
    mis   = is_mem(t) && !t.bop && (lane != 0);
    be    = t.bop ? 4'(1 << lane) : 4'hF;
    wdata = t.bop ? 32'(t.wd[7:0]) * 32'h0101_0101 : t.wd;
    if (is_mem(t) && !mis && !t.mw)
      rd_data = t.bop ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;
    else
      rd_data = 32'h0;
  endtask

  // driver
  task automatic drive(input instr_t t);
    alu_result_m_i = t.alu;  write_data_m_i = t.wd;
    pc_plus4_m_i   = t.pc;   imm_ext_m_i    = t.imm;
    rd_m_i         = t.rd;   result_src_m_i = t.rsrc;
    reg_write_m_i  = t.rw;   mem_write_m_i  = t.mw;  byte_op_m_i = t.bop;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_bub_rw"}, 32'(reg_write_w_o), 32'h0);
    chk({tag, "_bub_rd"}, 32'(rd_w_o), 32'h0);
    chk({tag, "_bub_data"},
        alu_result_w_o | read_data_w_o | pc_plus4_w_o | imm_ext_w_o | 32'(result_src_w_o), 32'h0);
  endtask

  // Runs one instruction through M; called and returning at a negedge
  task automatic run(input string tag, input vec_t v);
    logic go;
    logic [31:0] exp_req_data;
    go = is_mem(v.t) && !v.exp_mis;
    drive(v.t);
    dmem_ack_i   = 1'($urandom_range(0, 1));
    dmem_rdata_i = $urandom;
    #1 chk({tag, "_stall_c0"}, 32'(stall_m_o), 32'(go));
    @(negedge clk);
    dmem_ack_i = 1'b0;
    if (go) begin
      for (int n = 1; n <= v.ack_on; n++) begin
        chk({tag, "_req"}, 32'(dmem_req_o), 32'h1);
        chk({tag, "_we"}, 32'(dmem_we_o), 32'(v.t.mw));
        chk({tag, "_addr"}, dmem_addr_o, v.t.alu & 32'hFFFF_FFFC);
        chk({tag, "_be"}, 32'(dmem_be_o), 32'(v.exp_be));
        chk({tag, "_wdata"}, dmem_wdata_o, v.exp_wdata);
        chk({tag, "_mis_busy"}, 32'(misaligned_o), 32'h0);
        chk_bubble(tag);
        if (n == v.ack_on) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = v.rdata;
        end
        #1 chk({tag, "_stall_busy"}, 32'(stall_m_o), 32'h1);
        @(negedge clk);
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = $urandom;
      end
      chk({tag, "_req_drop"}, 32'(dmem_req_o), 32'h0);
      chk({tag, "_stall_done"}, 32'(stall_m_o), 32'h0);
      chk_bubble(tag);
      @(negedge clk);
    end else begin
      chk({tag, "_noreq"}, 32'(dmem_req_o), 32'h0);
    end
    exp_req_data = v.exp_read;
    chk({tag, "_w_alu"}, alu_result_w_o, v.t.alu);
    chk({tag, "_w_read"}, read_data_w_o, exp_req_data);
    chk({tag, "_w_pc"}, pc_plus4_w_o, v.t.pc);
    chk({tag, "_w_imm"}, imm_ext_w_o, v.t.imm);
    chk({tag, "_w_rd"}, 32'(rd_w_o), 32'(v.t.rd));
    chk({tag, "_w_rsrc"}, 32'(result_src_w_o), 32'(v.t.rsrc));
    chk({tag, "_w_rw"}, 32'(reg_write_w_o), 32'(v.t.rw && !v.exp_mis));
    chk({tag, "_mis"}, 32'(misaligned_o), 32'(v.exp_mis));
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] rd, input logic [1:0] rsrc,
                                input logic rw, input logic mw, input logic bop);
    instr_t t;
    t.alu = alu; t.wd = wd; t.pc = alu + 32'h1000; t.imm = ~alu;
    t.rd = rd; t.rsrc = rsrc; t.rw = rw; t.mw = mw; t.bop = bop;
    return t;
  endfunction

  vec_t vecs[10];
  instr_t zero_t;

  initial begin
    // directed table: {instr, ack cycle, rdata, be, wdata, read_data, misaligned}
    vecs[0] = '{mk(32'h1234, 32'h0, 5'd5, 2'b00, 1, 0, 0), 1, 32'h0, 4'hF, 32'h0, 32'h0, 0};
    vecs[1] = '{mk(32'h100, 32'h55, 5'd7, 2'b01, 1, 0, 0), 2, 32'hDEAD_BEEF, 4'hF, 32'h55, 32'hDEAD_BEEF, 0};
    vecs[2] = '{mk(32'h203, 32'h1234_56A5, 5'd0, 2'b00, 0, 1, 1), 3, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0};
    vecs[3] = '{mk(32'h202, 32'h0, 5'd9, 2'b01, 1, 0, 1), 1, 32'h1122_3344, 4'b0100, 32'h0, 32'h0000_0022, 0};
    vecs[4] = '{mk(32'h102, 32'h0, 5'd3, 2'b01, 1, 0, 0), 1, 32'h0, 4'hF, 32'h0, 32'h0, 1};
    vecs[5] = '{mk(32'h300, 32'hCAFE_F00D, 5'd0, 2'b00, 0, 1, 0), 1, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0, 0};
    vecs[6] = '{mk(32'h003, 32'h7F, 5'd11, 2'b01, 1, 0, 1), 4, 32'h80FF_7F01, 4'b1000, 32'h7F7F_7F7F, 32'h80, 0};
    vecs[7] = '{mk(32'h0ABC_DEF1, 32'h0, 5'd31, 2'b10, 0, 0, 0), 1, 32'h0, 4'hF, 32'h0, 32'h0, 0};
    vecs[8] = '{mk(32'h001, 32'h0, 5'd12, 2'b01, 1, 0, 1), 2, 32'hAABB_CCDD, 4'b0010, 32'h0, 32'hCC, 0};
    vecs[9] = '{mk(32'h101, 32'h9999, 5'd0, 2'b00, 1, 1, 0), 1, 32'h0, 4'hF, 32'h0, 32'h0, 1};

    zero_t = mk(32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 0);
    zero_t.pc = 32'h0; zero_t.imm = 32'h0;
    drive(zero_t);
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req_o), 32'h0);
    chk("rst_be_we", 32'({dmem_be_o, dmem_we_o}), 32'h0);
    chk("rst_addr_wdata", dmem_addr_o | dmem_wdata_o, 32'h0);
    chk("rst_mis", 32'(misaligned_o), 32'h0);
    chk_bubble("rst");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

    // reset while a load is in flight; a late ack must be ignored
    drive(vecs[1].t);
    @(negedge clk);
    chk("midrst_req_up", 32'(dmem_req_o), 32'h1);
    drive(zero_t);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_drop", 32'(dmem_req_o), 32'h0);
    chk("midrst_stall", 32'(stall_m_o), 32'h0);
    chk_bubble("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    #1 chk("late_ack_stall", 32'(stall_m_o), 32'h0);
    @(negedge clk);
    dmem_ack_i = 1'b0;
    chk("late_ack_req", 32'(dmem_req_o), 32'h0);
    chk("late_ack_read", read_data_w_o, 32'h0);
    chk("late_ack_rw", 32'(reg_write_w_o), 32'h0);
    @(negedge clk);
    chk("late_ack_idle", 32'(stall_m_o | dmem_req_o), 32'h0);

    // randomized instructions against the model
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      int kind;
      kind = $urandom_range(0, 3);
      v.t = mk($urandom, $urandom, 5'($urandom), 2'($urandom_range(0, 3)),
               1'($urandom), 1'b0, 1'($urandom));
      v.t.pc = $urandom; v.t.imm = $urandom;
      if (kind == 1) begin v.t.mw = 1'b1; v.t.rsrc = 2'($urandom_range(0, 3)); end
      if (kind == 2) v.t.rsrc = 2'b01;
      if (kind == 3 && v.t.rsrc == 2'b01) v.t.rsrc = 2'b00;
      if ($urandom_range(0, 2) != 0) v.t.alu[1:0] = 2'b00;
      v.ack_on = $urandom_range(1, 4);
      v.rdata  = $urandom;
      model(v.t, v.rdata, v.exp_be, v.exp_wdata, v.exp_read, v.exp_mis);
      run($sformatf("rnd%0d", i), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Memory (M) stage of the 5-stage pipeline. It sits directly downstream of the E/M pipeline register and upstream of the writeback mux.
- Issues loads and stores to the data memory over a req/ack handshake, stalling the pipeline until the access completes.
- Formats byte and word data.
- Contains the M/W pipeline register that feeds the writeback stage.

Parameters:
- DATA_WIDTH, 32, datapath width. Byte-lane logic requires exactly 32.
- REGISTER_WIDTH, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- alu_result_m_i  input  DATA_WIDTH  address or ALU result from the E/M register.
- write_data_m_i  input  DATA_WIDTH  store data.
- pc_plus4_m_i  input  DATA_WIDTH  PC+4 forwarded to W.
- imm_ext_m_i  input  DATA_WIDTH  extended immediate forwarded to W.
- rd_m_i  input  REGISTER_WIDTH  destination register.
- result_src_m_i  input  2  writeback select; 2'b01 = load.
- reg_write_m_i, mem_write_m_i, byte_op_m_i  input  1 each  control bits.
- dmem_req_o  output  1  memory request.
- dmem_we_o  output  1  1 = store.
- dmem_addr_o  output  DATA_WIDTH  word-aligned address.
- dmem_wdata_o  output  DATA_WIDTH  store data.
- dmem_be_o  output  4  byte enables.
- dmem_ack_i  input  1  memory completion.
- dmem_rdata_i  input  DATA_WIDTH  read data, valid when ack is high.
- stall_m_o  output  1  to the hazard unit; freezes F/D/E/M registers.
- misaligned_o  output  1  one-cycle pulse on a misaligned word access.
- alu_result_w_o, read_data_w_o, pc_plus4_w_o, imm_ext_w_o  output  DATA_WIDTH  M/W register outputs.
- rd_w_o  output  REGISTER_WIDTH  M/W register output.
- result_src_w_o  output  2  M/W register output.
- reg_write_w_o  output  1  M/W register output.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and all registered outputs to 0 (req, we, addr, wdata, be, misaligned, all *_w_o). Any in-flight request is abandoned. An ack arriving after reset is ignored.
- Memory op: mem_write_m_i=1, or result_src_m_i==2'b01 with mem_write_m_i=0.
- Misaligned: byte_op_m_i=0 and alu_result_m_i[1:0]!=0. The access is not issued.
  - The instruction passes to W in one cycle with reg_write_w_o forced to 0.
  - misaligned_o=1 for that cycle.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE, aligned memory op present:
  - stall_m_o=1 (combinational).
  - Next state BUSY.
  - Registers dmem_req_o=1, dmem_we_o, dmem_addr_o={addr[31:2],2'b00}, dmem_be_o and dmem_wdata_o.
  - W register loads a bubble.
- IDLE, non-memory op or misaligned: stall_m_o=0; the W register captures the M inputs (read_data_w_o=0). Latency is 1 cycle.
- BUSY:
  - stall_m_o=1; request fields held stable; W register loads a bubble.
  - On dmem_ack_i=1: dmem_req_o drops next cycle, formatted load data is captured into an internal buffer, next state DONE.
  - No ack: remain in BUSY indefinitely (no timeout).
- DONE:
  - stall_m_o=0.
  - W register captures the M inputs with read_data_w_o = buffer (0 for stores).
  - Next state IDLE.
  - A back-to-back memory op is seen in the following IDLE cycle.
- Minimum memory-op latency, M entry to W valid: 3 cycles with ack on the first req cycle.
- Bubble: reg_write_w_o=0, rd_w_o=0, result_src_w_o=0, data outputs=0.
- Byte store: dmem_be_o = 4'b0001 << addr[1:0]; dmem_wdata_o = write_data[7:0] replicated on all four lanes.
- Byte load: zero-extended byte from lane addr[1:0] of dmem_rdata_i.
- Word access: dmem_be_o=4'b1111; wdata and rdata pass unchanged.
- dmem_be_o is also driven for loads; memory may ignore it.
- dmem_ack_i outside BUSY is ignored.
- The upstream E/M register holds its outputs while stall_m_o=1. M inputs are sampled only in IDLE and DONE.

Test Plan:
- Reset mid-BUSY (req=1) -> req drops immediately; W outputs 0; a late ack causes no W update and state stays IDLE.
- ALU op (result_src=00, rd=5, alu_result=0x1234), no memory op -> next cycle rd_w_o=5, reg_write_w_o=1, alu_result_w_o=0x1234; stall_m_o never asserted.
- Word load at addr 0x100, ack 2 cycles after req with rdata 0xDEADBEEF:
  - stall_m_o high for 3 cycles;
  - dmem_addr_o=0x100, be=4'b1111;
  - then read_data_w_o=0xDEADBEEF with exactly one W write.
- Byte store of 0xA5 at addr 0x203 -> be=4'b1000, wdata=0xA5A5A5A5, we=1; reg_write_w_o=0 bubbles during the stall.
- Byte load at addr 0x202, rdata 0x11223344 -> read_data_w_o=0x00000022.
- Word load at addr 0x102 -> no req, misaligned_o pulses for 1 cycle, reg_write_w_o=0, no stall.
